adbg_top_mux: RTL and testbench
===============================

# adbg_top_mux

Parametrised JTAG debug top-level selector for the advanced debug interface: shifts the debug data register, decodes module-select commands and routes `tdo_o` from one of `NB_MODULES` debug sub-modules. It adds three things over a fixed two-module selector:

- Deferred selection while a sub-module inhibits.
- Explicit invalid-ID detection.
- A readable status word when no valid module is selected.

It sits between the TAP controller and the debug sub-modules (AXI, CPU, …).

## Interface
Parameters:
- `NB_MODULES`, default 2: number of attached debug sub-modules (1..32, and ≤ 2^`MODULE_ID_WIDTH`).
- `MODULE_ID_WIDTH`, default 5: width of the module ID field.
- `DATA_LEN`, default 64: length of the input shift register (≥ `MODULE_ID_WIDTH`+1).
- `RESET_MODULE`, default 0: module ID selected after reset. It must be < `NB_MODULES`; any other value is an elaboration error.

Ports:
- `tck_i` — in, 1: JTAG clock; all state updates on posedge.
- `trstn_i` — in, 1: reset, asynchronous, active-low.
- `tdi_i` — in, 1: JTAG serial data in.
- `tdo_o` — out, 1: serial data out (combinational mux).
- `shift_dr_i`, `pause_dr_i`, `update_dr_i`, `capture_dr_i` — in, 1 each: TAP state indications.
- `debug_select_i` — in, 1: debug instruction active in the IR.
- `data_register_o` — out, `DATA_LEN`: input shift register contents, to every sub-module.
- `module_select_o` — out, `NB_MODULES`: one-hot select, or all-zero when the current ID is invalid.
- `module_tdo_i` — in, `NB_MODULES`: per-module TDO.
- `module_inhibit_i` — in, `NB_MODULES`: per-module request to block reselection.
- `select_error_o` — out, 1: current module ID is ≥ `NB_MODULES`.
- `select_pending_o` — out, 1: a select command is deferred by an inhibit.

## Operation
Shift register:
- When `debug_select_i && shift_dr_i`, the register shifts right: `{tdi_i, sr[DATA_LEN-1:1]}`.
- Otherwise it holds, including during pause. `pause_dr_i` has no further effect.

Select command:
- A select command is `debug_select_i && update_dr_i && sr[DATA_LEN-1]`.
- The command's ID is `sr[DATA_LEN-2 -: MODULE_ID_WIDTH]`.

Command handling:
- **Inhibit low** (`|module_inhibit_i` = 0): `module_id_reg` ← ID. Any pending command is discarded.
- **Inhibit high**:
  - `pend_id` ← ID and `pend_valid` ← 1.
  - A later select command while pending overwrites `pend_id` (last command wins).
- **Pending drain:** on any posedge where `pend_valid` = 1, inhibit is low and no new select command is present:
  - `module_id_reg` ← `pend_id`, `pend_valid` ← 0.
  - Draining does not require `debug_select_i`.
- **Simultaneous events:**
  - A new command with inhibit low beats the drain: the new ID is loaded and pending is cleared.
  - A new command with inhibit high overwrites `pend_id`.

Select decode:
- `select_error_o` = (`module_id_reg` ≥ `NB_MODULES`), registered alongside `module_id_reg`.
- `module_select_o[i]` = (`module_id_reg` == i).

TDO mux:
- Valid ID: `tdo_o` = `module_tdo_i[module_id_reg]`.
- Invalid ID: `tdo_o` = `stat_sr[0]`.

Status word (`STAT_LEN` = `MODULE_ID_WIDTH`+2):
- On `capture_dr_i && debug_select_i`, `stat_sr` ← `{pend_valid, select_error, module_id_reg}`.
- On shift, `stat_sr` shifts right with zero fill; it holds otherwise.
- The status word is only observable when the current ID is invalid.

Reset values (`trstn_i` low, immediate):
- `sr` = 0, `stat_sr` = 0.
- `module_id_reg` = `RESET_MODULE`.
- `pend_valid` = 0, `pend_id` = 0.
- `select_error_o` = 0, `select_pending_o` = 0.
- `module_select_o` = one-hot(`RESET_MODULE`).
- `tdo_o` = `module_tdo_i[RESET_MODULE]`.
- Reset mid-shift or mid-pending discards all state; no deferred select survives reset.

## Timing
- Select takes effect one tck after the update_dr edge: `module_select_o` and `tdo_o` change after that posedge.
- A deferred select takes effect one tck after the first posedge that samples inhibit low.
- `select_pending_o` rises one tck after the inhibited update and falls with the drain edge.
- `tdo_o` is purely combinational from `module_id_reg`, `stat_sr` and `module_tdo_i`. There is no internal negedge retiming; the TAP controller owns that.
- `data_register_o` equals `sr` directly, with zero latency.

## Structure
- Package `adbg_pkg` holds:
  - `ADBG_DATA_LEN_DEFAULT` (64) and `ADBG_MODULE_ID_WIDTH_DEFAULT` (5).
  - Status-word field offsets: `STAT_ID_LSB` = 0, `STAT_ERR_BIT` = `MODULE_ID_WIDTH`, `STAT_PEND_BIT` = `MODULE_ID_WIDTH`+1.
- Sub-module `adbg_select_ctrl` contains `module_id_reg`, `pend_id`/`pend_valid`, error decode and one-hot generation.
- The top level keeps the shift register, the status shift register and the TDO mux.

## Test plan
All scenarios use `NB_MODULES`=3, `MODULE_ID_WIDTH`=5, `DATA_LEN`=64.

- **Reset:** assert `trstn_i` mid-shift → `module_select_o`=3'b001, `select_error_o`=0, `sr`=0; `tdo_o` follows `module_tdo_i[0]`.
- **Valid select:** shift 64 bits with MSB=1 and ID=2, then pulse update_dr → one tck later `module_select_o`=3'b100 and `tdo_o`=`module_tdo_i[2]`.
- **Deferred select:** hold `module_inhibit_i`=3'b001, select ID=1, then ID=2 → `select_pending_o`=1 and select unchanged (3'b001). Release inhibit → next posedge gives `module_select_o`=3'b100, `select_pending_o`=0.
- **Invalid ID:** select ID=5'h07 → `select_error_o`=1 and `module_select_o`=0. Capture then shift 7 bits → `tdo_o` emits 1,1,1,0,0,1,0 (ID=7 LSB first, err=1, pend=0), then zeros.
- **Simultaneous events:** pending ID=1 with inhibit dropping on the same edge as a new select ID=0 → `module_id_reg`=0, pending cleared, no transient select of ID 1.
- **Non-select update:** update_dr with MSB=0, or with `debug_select_i`=0 → `module_id_reg` unchanged; the `sr` contents remain visible on `data_register_o`.

Source files
------------

// File: rtl/adbg_pkg.sv
// Shared constants for the advanced debug top-level selector: default sizes
// and the layout of the status word returned when no valid module is selected.
package adbg_pkg;

    localparam int ADBG_DATA_LEN_DEFAULT        = 64;
    localparam int ADBG_MODULE_ID_WIDTH_DEFAULT = 5;

    // Status word layout {pend_valid, select_error, module_id}, for the default ID width
    localparam int STAT_ID_LSB   = 0;
    localparam int STAT_ERR_BIT  = ADBG_MODULE_ID_WIDTH_DEFAULT;
    localparam int STAT_PEND_BIT = ADBG_MODULE_ID_WIDTH_DEFAULT + 1;

    // Same offsets for an arbitrary ID width
    function automatic int stat_err_bit(input int id_width);
        return id_width;
    endfunction

    function automatic int stat_pend_bit(input int id_width);
        return id_width + 1;
    endfunction

endpackage

// File: rtl/adbg_select_ctrl.sv
// Module-ID selection: applies select commands immediately, or defers them while
// any sub-module inhibits, and decodes the current ID into error flag and one-hot.
module adbg_select_ctrl
    import adbg_pkg::*;
#(
    parameter int NB_MODULES      = 2,
    parameter int MODULE_ID_WIDTH = ADBG_MODULE_ID_WIDTH_DEFAULT,
    parameter int RESET_MODULE    = 0
) (
    input  logic                       tck_i,
    input  logic                       trstn_i,
    input  logic                       cmd_valid,
    input  logic [MODULE_ID_WIDTH-1:0] cmd_id,
    input  logic                       inhibit,
    output logic [MODULE_ID_WIDTH-1:0] module_id,
    output logic                       select_error,
    output logic                       pend_valid,
    output logic [NB_MODULES-1:0]      module_select
);

    logic [MODULE_ID_WIDTH-1:0] module_id_reg, module_id_next;
    logic [MODULE_ID_WIDTH-1:0] pend_id_reg, pend_id_next;
    logic                       pend_valid_reg, pend_valid_next;
    logic                       select_error_reg;

    // A fresh command always wins over draining an older deferred one
    always_comb begin
        module_id_next  = module_id_reg;
        pend_id_next    = pend_id_reg;
        pend_valid_next = pend_valid_reg;
        if (cmd_valid) begin
            if (!inhibit) begin
                module_id_next  = cmd_id;
                pend_valid_next = 1'b0;
            end else begin
                pend_id_next    = cmd_id;
                pend_valid_next = 1'b1;
            end
        end else if (pend_valid_reg && !inhibit) begin
            module_id_next  = pend_id_reg;
            pend_valid_next = 1'b0;
        end
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            module_id_reg    <= MODULE_ID_WIDTH'(RESET_MODULE);
            pend_id_reg      <= '0;
            pend_valid_reg   <= 1'b0;
            select_error_reg <= 1'b0;
        end else begin
            module_id_reg    <= module_id_next;
            pend_id_reg      <= pend_id_next;
            pend_valid_reg   <= pend_valid_next;
            select_error_reg <= (32'(module_id_next) >= 32'(NB_MODULES));
        end
    end

    for (genvar gi = 0; gi < NB_MODULES; gi++) begin : g_onehot
        assign module_select[gi] = (module_id_reg == MODULE_ID_WIDTH'(gi));
    end

    assign module_id    = module_id_reg;
    assign select_error = select_error_reg;
    assign pend_valid   = pend_valid_reg;

endmodule

// File: rtl/adbg_top_mux.sv
// JTAG debug top-level selector: shifts the debug data register, hands select
// commands to the selection controller and muxes TDO (or the status word).
module adbg_top_mux
    import adbg_pkg::*;
#(
    parameter int NB_MODULES      = 2,
    parameter int MODULE_ID_WIDTH = ADBG_MODULE_ID_WIDTH_DEFAULT,
    parameter int DATA_LEN        = ADBG_DATA_LEN_DEFAULT,
    parameter int RESET_MODULE    = 0
) (
    input  logic                  tck_i,
    input  logic                  trstn_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic                  shift_dr_i,
    input  logic                  pause_dr_i,
    input  logic                  update_dr_i,
    input  logic                  capture_dr_i,
    input  logic                  debug_select_i,
    output logic [DATA_LEN-1:0]   data_register_o,
    output logic [NB_MODULES-1:0] module_select_o,
    input  logic [NB_MODULES-1:0] module_tdo_i,
    input  logic [NB_MODULES-1:0] module_inhibit_i,
    output logic                  select_error_o,
    output logic                  select_pending_o
);

    localparam int STAT_LEN = MODULE_ID_WIDTH + 2;
    localparam int ERR_BIT  = stat_err_bit(MODULE_ID_WIDTH);
    localparam int PEND_BIT = stat_pend_bit(MODULE_ID_WIDTH);

    if (RESET_MODULE < 0 || RESET_MODULE >= NB_MODULES) begin : g_bad_reset_module
        $fatal(1, "adbg_top_mux: RESET_MODULE must be below NB_MODULES");
    end

    logic [DATA_LEN-1:0]        sr_reg;
    logic [STAT_LEN-1:0]        stat_reg, stat_capture;
    logic                       shift_en, cmd_valid;
    logic [MODULE_ID_WIDTH-1:0] module_id;
    logic                       select_error, pend_valid;
    logic                       unused_pause;

    // Pause simply holds the registers, which is what the shift gating already does
    assign unused_pause = pause_dr_i;
    assign shift_en     = debug_select_i && shift_dr_i;
    assign cmd_valid    = debug_select_i && update_dr_i && sr_reg[DATA_LEN-1];

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            sr_reg <= '0;
        end else if (shift_en) begin
            sr_reg <= {tdi_i, sr_reg[DATA_LEN-1:1]};
        end
    end

    adbg_select_ctrl #(
        .NB_MODULES      (NB_MODULES),
        .MODULE_ID_WIDTH (MODULE_ID_WIDTH),
        .RESET_MODULE    (RESET_MODULE)
    ) u_select_ctrl (
        .tck_i         (tck_i),
        .trstn_i       (trstn_i),
        .cmd_valid     (cmd_valid),
        .cmd_id        (sr_reg[DATA_LEN-2 -: MODULE_ID_WIDTH]),
        .inhibit       (|module_inhibit_i),
        .module_id     (module_id),
        .select_error  (select_error),
        .pend_valid    (pend_valid),
        .module_select (module_select_o)
    );

    always_comb begin
        stat_capture                                 = '0;
        stat_capture[STAT_ID_LSB +: MODULE_ID_WIDTH] = module_id;
        stat_capture[ERR_BIT]                        = select_error;
        stat_capture[PEND_BIT]                       = pend_valid;
    end

    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            stat_reg <= '0;
        end else if (capture_dr_i && debug_select_i) begin
            stat_reg <= stat_capture;
        end else if (shift_en) begin
            stat_reg <= {1'b0, stat_reg[STAT_LEN-1:1]};
        end
    end

    // module_select_o is one-hot for a valid ID, so AND-OR is the TDO mux
    assign tdo_o            = select_error ? stat_reg[0] : |(module_select_o & module_tdo_i);
    assign data_register_o  = sr_reg;
    assign select_error_o   = select_error;
    assign select_pending_o = pend_valid;

endmodule

// File: tb/tb_adbg_top_mux.sv
// Bench for adbg_top_mux with three modules: directed JTAG sequences, a behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_adbg_top_mux;

    localparam int NB = 3;
    localparam int IW = 5;
    localparam int DL = 64;

    logic          tck = 1'b0;
    logic          trstn;
    logic          tdi = 1'b0;
    logic          tdo;
    logic          shift_dr = 1'b0, pause_dr = 1'b0, update_dr = 1'b0, capture_dr = 1'b0;
    logic          dsel = 1'b0;
    logic [DL-1:0] dreg;
    logic [NB-1:0] msel;
    logic [NB-1:0] mtdo = '0;
    logic [NB-1:0] minh = '0;
    logic          serr, spend;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    adbg_top_mux #(
        .NB_MODULES(NB), .MODULE_ID_WIDTH(IW), .DATA_LEN(DL), .RESET_MODULE(0)
    ) dut (
        .tck_i(tck), .trstn_i(trstn), .tdi_i(tdi), .tdo_o(tdo),
        .shift_dr_i(shift_dr), .pause_dr_i(pause_dr), .update_dr_i(update_dr),
        .capture_dr_i(capture_dr), .debug_select_i(dsel),
        .data_register_o(dreg), .module_select_o(msel),
        .module_tdo_i(mtdo), .module_inhibit_i(minh),
        .select_error_o(serr), .select_pending_o(spend)
    );

    always #5 tck = ~tck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: current ID, deferred ID, shift register and status value
    int      m_id, m_pend_id;
    bit      m_pend;
    bit [63:0] m_sr;
    int      m_stat;

    always @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            m_id = 0; m_pend = 0; m_pend_id = 0; m_sr = '0; m_stat = 0;
        end else begin
            int  new_id;
            bit  cmd, inh;
            if (dsel && capture_dr)
                m_stat = (m_pend ? 64 : 0) + ((m_id >= NB) ? 32 : 0) + m_id;
            else if (dsel && shift_dr)
                m_stat = m_stat / 2;
            cmd    = dsel && update_dr && m_sr[63];
            new_id = int'((m_sr >> 58) & 64'd31);
            inh    = (minh != 0);
            if (cmd && !inh) begin
                m_id = new_id; m_pend = 0;
            end else if (cmd) begin
                m_pend = 1; m_pend_id = new_id;
            end else if (m_pend && !inh) begin
                m_id = m_pend_id; m_pend = 0;
            end
            if (dsel && shift_dr) m_sr = {tdi, m_sr[63:1]};
        end
    end

    always @(negedge tck) begin
        if (check_en) begin
            logic [NB-1:0] e_sel;
            logic          e_tdo;
            e_sel = (m_id < NB) ? NB'(1 << m_id) : '0;
            e_tdo = (m_id < NB) ? mtdo[m_id] : m_stat[0];
            chk("model_select", 64'(msel), 64'(e_sel));
            chk("model_error", 64'(serr), 64'(m_id >= NB));
            chk("model_pending", 64'(spend), 64'(m_pend));
            chk("model_dreg", dreg, m_sr);
            chk("model_tdo", 64'(tdo), 64'(e_tdo));
        end
    end

    task automatic tick();
        @(posedge tck);
        #1;
        mtdo = NB'($urandom_range(0, 7));
    endtask

    function automatic logic [63:0] cmd_word(input logic [4:0] id);
        logic [63:0] w;
        w = '0;
        w[63] = 1'b1;
        w[62:58] = id;
        return w;
    endfunction

    task automatic shift_word(input logic [63:0] w);
        dsel = 1'b1;
        shift_dr = 1'b1;
        for (int i = 0; i < DL; i++) begin
            tdi = w[i];
            tick();
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic update(input logic sel);
        dsel = sel;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        dsel = 1'b1;
    endtask

    initial begin
        logic [6:0] exp_bits;
        logic [63:0] plain;
        trstn = 1'b0;
        #12;
        check_en = 1'b1;
        #10;
        trstn = 1'b1;
        tick();
        @(negedge tck);
        chk("reset_select", 64'(msel), 64'h1);
        chk("reset_error", 64'(serr), 64'h0);

        // Valid select of ID 2
        shift_word(cmd_word(5'd2));
        update(1'b1);
        @(negedge tck);
        chk("valid_select", 64'(msel), 64'h4);
        chk("valid_tdo", 64'(tdo), 64'(mtdo[2]));

        // Reset in the middle of a shift
        dsel = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        trstn = 1'b0;
        #1;
        chk("midshift_reset_select", 64'(msel), 64'h1);
        chk("midshift_reset_dreg", dreg, 64'h0);
        chk("midshift_reset_error", 64'(serr), 64'h0);
        chk("midshift_reset_tdo", 64'(tdo), 64'(mtdo[0]));
        shift_dr = 1'b0; tdi = 1'b0;
        tick();
        trstn = 1'b1;
        tick();

        // Deferred select: ID1 then ID2 while inhibited; last one wins
        minh = 3'b001;
        shift_word(cmd_word(5'd1));
        update(1'b1);
        shift_word(cmd_word(5'd2));
        update(1'b1);
        @(negedge tck);
        chk("deferred_pending", 64'(spend), 64'h1);
        chk("deferred_hold_select", 64'(msel), 64'h1);
        minh = 3'b000;
        tick();
        @(negedge tck);
        chk("deferred_drain_select", 64'(msel), 64'h4);
        chk("deferred_drain_pending", 64'(spend), 64'h0);

        // Invalid ID 7 and status word readout
        shift_word(cmd_word(5'd7));
        update(1'b1);
        @(negedge tck);
        chk("invalid_error", 64'(serr), 64'h1);
        chk("invalid_select", 64'(msel), 64'h0);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        exp_bits = 7'b0100111;
        shift_dr = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge tck);
            chk($sformatf("status_bit%0d", k), 64'(tdo), 64'((k < 7) ? exp_bits[k] : 1'b0));
            tick();
        end
        shift_dr = 1'b0;

        // Simultaneous: pending ID1, inhibit drops with a new select of ID0
        minh = 3'b010;
        shift_word(cmd_word(5'd1));
        update(1'b1);
        shift_word(cmd_word(5'd0));
        minh = 3'b000;
        update(1'b1);
        @(negedge tck);
        chk("simul_select", 64'(msel), 64'h1);
        chk("simul_pending", 64'(spend), 64'h0);
        chk("simul_error", 64'(serr), 64'h0);
        tick();
        @(negedge tck);
        chk("simul_no_transient", 64'(msel), 64'h1);

        // Non-select updates: MSB clear, then debug_select low
        plain = 64'h7C00_1234_5678_9ABC;
        shift_word(plain);
        update(1'b1);
        @(negedge tck);
        chk("msb0_select", 64'(msel), 64'h1);
        chk("msb0_dreg", dreg, plain);
        shift_word(cmd_word(5'd2));
        update(1'b0);
        @(negedge tck);
        chk("nodsel_select", 64'(msel), 64'h1);
        chk("nodsel_dreg", dreg, cmd_word(5'd2));

        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
